rab_arbiter: RTL and testbench

- Shares the single register-access bus (RAB) master port between two requesters: port 0 is the I2C slave bridge, port 1 is the MCU/SPI host.
- Each requester's one-cycle write/read strobe is captured into a one-deep pending slot.
- Pending slots are granted round-robin, or with fixed priority, and the single transaction is sequenced on the RAB.
- Completion is returned to the owner. A timeout recovers from a missing rab_ack.

---
 rtl/rab_pkg.sv | 16 +
 rtl/rab_req_slot.sv | 76 +++++++
 rtl/rab_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_rab_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rab_pkg.sv
// Shared definitions for the register-access-bus arbiter: bus widths,
// FSM state encoding and the request-kind encoding held in each pending slot.
package rab_pkg;

    localparam int RAB_AW = 9;
    localparam int RAB_DW = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } rab_state_e;

    localparam logic KIND_WR = 1'b1;
    localparam logic KIND_RD = 1'b0;

endpackage

// File: rtl/rab_req_slot.sv
// One-deep pending slot for a single requester. A strobe is only accepted
// into an empty slot; a strobe that finds the slot occupied (even if it is
// being cleared in the same cycle) is dropped and reported with a one-cycle
// drop pulse. A simultaneous write+read keeps the write and reports the read.
module rab_req_slot
    import rab_pkg::*;
(
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              wr_i,
    input  logic              rd_i,
    input  logic [RAB_AW-1:0] addr_i,
    input  logic [RAB_DW-1:0] wdata_i,
    input  logic              clr_i,
    output logic              pend_o,
    output logic              kind_o,
    output logic [RAB_AW-1:0] addr_o,
    output logic [RAB_DW-1:0] wdata_o,
    output logic              drop_o
);

    logic              pend_q, pend_d;
    logic              kind_q, kind_d;
    logic              drop_q, drop_d;
    logic [RAB_AW-1:0] addr_q, addr_d;
    logic [RAB_DW-1:0] wdata_q, wdata_d;

    // Next-state: capture into an empty slot, otherwise flag the strobe as dropped.
    always_comb begin
        pend_d  = pend_q;
        kind_d  = kind_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        drop_d  = 1'b0;
        if (pend_q) begin
            if (clr_i) begin
                pend_d = 1'b0;
            end
            if (wr_i || rd_i) begin
                drop_d = 1'b1;
            end
        end else if (wr_i || rd_i) begin
            pend_d  = 1'b1;
            kind_d  = wr_i ? KIND_WR : KIND_RD;
            addr_d  = addr_i;
            wdata_d = wdata_i;
            drop_d  = wr_i && rd_i;
        end
    end

    // Control state: occupancy, kind and drop pulse, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            pend_q <= 1'b0;
            kind_q <= KIND_RD;
            drop_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            kind_q <= kind_d;
            drop_q <= drop_d;
        end
    end

    // Payload registers; only meaningful while the slot is pending.
    always_ff @(posedge clk_i) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign pend_o  = pend_q;
    assign kind_o  = kind_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign drop_o  = drop_q;

endmodule

// File: rtl/rab_arbiter.sv
// Two-port arbiter for the register-access bus. Port 0 is the I2C slave
// bridge, port 1 the MCU/SPI host. Each port owns a one-deep pending slot;
// an IDLE/WAIT FSM picks a winner (round-robin or port-0 priority), issues a
// one-cycle RAB strobe, waits for rab_ack or a timeout, and returns the
// completion (ack, read data, timeout error) to the owning port.
module rab_arbiter
    import rab_pkg::*;
#(
    parameter bit                 RR_EN         = 1'b1,
    parameter int unsigned        TIMEOUT_CYC   = 255,
    parameter logic [RAB_DW-1:0]  TIMEOUT_RDATA = 8'hFF
) (
    input  logic              sys_clk,
    input  logic              io_resetb,
    input  logic              req0_write,
    input  logic              req0_read,
    input  logic [RAB_AW-1:0] req0_addr,
    input  logic [RAB_DW-1:0] req0_wdata,
    output logic              req0_busy,
    output logic              req0_ack,
    output logic [RAB_DW-1:0] req0_rdata,
    output logic              req0_err,
    input  logic              req1_write,
    input  logic              req1_read,
    input  logic [RAB_AW-1:0] req1_addr,
    input  logic [RAB_DW-1:0] req1_wdata,
    output logic              req1_busy,
    output logic              req1_ack,
    output logic [RAB_DW-1:0] req1_rdata,
    output logic              req1_err,
    output logic              rab_write,
    output logic              rab_read,
    output logic [RAB_AW-1:0] rab_addr,
    output logic [RAB_DW-1:0] rab_wdata,
    input  logic              rab_ack,
    input  logic [RAB_DW-1:0] rab_rdata,
    output logic              grant_id
);

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);

    logic [1:0]             slot_pend;
    logic [1:0]             slot_kind;
    logic [1:0]             slot_drop;
    logic [1:0]             slot_clr;
    logic [1:0][RAB_AW-1:0] slot_addr;
    logic [1:0][RAB_DW-1:0] slot_wdata;

    rab_state_e             state_q, state_d;
    logic                   rr_last_q, rr_last_d;
    logic                   grant_q, grant_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   rab_wr_q, rab_wr_d;
    logic                   rab_rd_q, rab_rd_d;
    logic [RAB_AW-1:0]      rab_addr_q, rab_addr_d;
    logic [RAB_DW-1:0]      rab_wdata_q, rab_wdata_d;
    logic [1:0]             ack_q, ack_d;
    logic [1:0]             terr_q, terr_d;
    logic [1:0][RAB_DW-1:0] rdata_q, rdata_d;

    logic                   win;
    logic                   done;
    logic                   tmo;
    logic [7:0]             cnt_inc;

    rab_req_slot u_slot0 (
        .clk_i   (sys_clk),
        .rstn_i  (io_resetb),
        .wr_i    (req0_write),
        .rd_i    (req0_read),
        .addr_i  (req0_addr),
        .wdata_i (req0_wdata),
        .clr_i   (slot_clr[0]),
        .pend_o  (slot_pend[0]),
        .kind_o  (slot_kind[0]),
        .addr_o  (slot_addr[0]),
        .wdata_o (slot_wdata[0]),
        .drop_o  (slot_drop[0])
    );

    rab_req_slot u_slot1 (
        .clk_i   (sys_clk),
        .rstn_i  (io_resetb),
        .wr_i    (req1_write),
        .rd_i    (req1_read),
        .addr_i  (req1_addr),
        .wdata_i (req1_wdata),
        .clr_i   (slot_clr[1]),
        .pend_o  (slot_pend[1]),
        .kind_o  (slot_kind[1]),
        .addr_o  (slot_addr[1]),
        .wdata_o (slot_wdata[1]),
        .drop_o  (slot_drop[1])
    );

    // FSM next-state: grant from IDLE, then complete on rab_ack or timeout in WAIT.
    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        rab_wr_d    = 1'b0;
        rab_rd_d    = 1'b0;
        rab_addr_d  = rab_addr_q;
        rab_wdata_d = rab_wdata_q;
        ack_d       = 2'b00;
        terr_d      = 2'b00;
        rdata_d     = rdata_q;
        slot_clr    = 2'b00;
        win         = 1'b0;
        done        = 1'b0;
        tmo         = 1'b0;
        cnt_inc     = cnt_q + 8'd1;
        case (state_q)
            ST_IDLE: begin
                if (|slot_pend) begin
                    // With both pending, round-robin favours the port not served last.
                    if (&slot_pend) begin
                        win = RR_EN ? ~rr_last_q : 1'b0;
                    end else begin
                        win = slot_pend[1];
                    end
                    grant_d     = win;
                    rr_last_d   = win;
                    cnt_d       = 8'd0;
                    rab_wr_d    = (slot_kind[win] == KIND_WR);
                    rab_rd_d    = (slot_kind[win] == KIND_RD);
                    rab_addr_d  = slot_addr[win];
                    rab_wdata_d = slot_wdata[win];
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // An ack in the limit cycle takes precedence over the timeout.
                if (rab_ack) begin
                    done = 1'b1;
                end else if (cnt_inc == TO_LIM) begin
                    done = 1'b1;
                    tmo  = 1'b1;
                end
                cnt_d = cnt_inc;
                if (done) begin
                    state_d           = ST_IDLE;
                    slot_clr[grant_q] = 1'b1;
                    ack_d[grant_q]    = 1'b1;
                    terr_d[grant_q]   = tmo;
                    if (slot_kind[grant_q] == KIND_RD) begin
                        rdata_d[grant_q] = tmo ? TIMEOUT_RDATA : rab_rdata;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and output registers; reset aborts any transaction without a completion.
    always_ff @(posedge sys_clk) begin
        if (!io_resetb) begin
            state_q     <= ST_IDLE;
            rr_last_q   <= 1'b1;
            grant_q     <= 1'b0;
            cnt_q       <= 8'd0;
            rab_wr_q    <= 1'b0;
            rab_rd_q    <= 1'b0;
            rab_addr_q  <= '0;
            rab_wdata_q <= '0;
            ack_q       <= 2'b00;
            terr_q      <= 2'b00;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            rab_wr_q    <= rab_wr_d;
            rab_rd_q    <= rab_rd_d;
            rab_addr_q  <= rab_addr_d;
            rab_wdata_q <= rab_wdata_d;
            ack_q       <= ack_d;
            terr_q      <= terr_d;
            rdata_q     <= rdata_d;
        end
    end

    assign req0_busy  = slot_pend[0];
    assign req1_busy  = slot_pend[1];
    assign req0_ack   = ack_q[0];
    assign req1_ack   = ack_q[1];
    assign req0_err   = slot_drop[0] | terr_q[0];
    assign req1_err   = slot_drop[1] | terr_q[1];
    assign req0_rdata = rdata_q[0];
    assign req1_rdata = rdata_q[1];
    assign rab_write  = rab_wr_q;
    assign rab_read   = rab_rd_q;
    assign rab_addr   = rab_addr_q;
    assign rab_wdata  = rab_wdata_q;
    assign grant_id   = grant_q;

endmodule

// File: tb/tb_rab_arbiter.sv
// Testbench for rab_arbiter: a vector table for single-port sequences,
// hand-written multi-cycle sequences (read return, contention, timeout,
// reset mid-transaction) and a randomized run against a queue-based model.
module tb_rab_arbiter;
    import rab_pkg::*;

    localparam int TO = 4;
    localparam bit RR = 1'b1;

    typedef struct packed {
        logic       w0;
        logic       r0;
        logic [8:0] a0;
        logic [7:0] d0;
        logic       ack;
        logic [7:0] ard;
    } tin_t;

    typedef struct packed {
        logic       b0, b1, k0, k1, e0, e1, rw, rr;
        logic [8:0] addr;
        logic [7:0] wd;
        logic       gid;
        logic [7:0] rd0, rd1;
    } outs_t;

    typedef struct {
        tin_t  in;
        outs_t ex;
    } vec_t;

    typedef struct {
        bit         wr;
        logic [8:0] a;
        logic [7:0] d;
    } mreq_t;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       w0 = 0, r0 = 0, w1 = 0, r1 = 0;
    logic [8:0] a0 = '0, a1 = '0;
    logic [7:0] d0 = '0, d1 = '0;
    logic       ack_in = 1'b0;
    logic [7:0] rdata_in = '0;

    logic       busy0, busy1, ack0, ack1, err0, err1, rw, rr, gid;
    logic [7:0] rd0, rd1, rwd;
    logic [8:0] raddr;
    logic       f_busy0, f_busy1, f_ack0, f_ack1, f_err0, f_err1, f_rw, f_rr, f_gid;
    logic [7:0] f_rd0, f_rd1, f_rwd;
    logic [8:0] f_raddr;

    int n_chk = 0;
    int n_err = 0;

    vec_t  tbl [19];
    mreq_t mq0[$];
    mreq_t mq1[$];
    bit    m_act;
    int    m_port, m_age, m_rr;
    outs_t m_exp;

    always #5 clk = ~clk;

    rab_arbiter #(.RR_EN(1'b1), .TIMEOUT_CYC(TO), .TIMEOUT_RDATA(8'hFF)) dut (
        .sys_clk(clk), .io_resetb(rstb),
        .req0_write(w0), .req0_read(r0), .req0_addr(a0), .req0_wdata(d0),
        .req0_busy(busy0), .req0_ack(ack0), .req0_rdata(rd0), .req0_err(err0),
        .req1_write(w1), .req1_read(r1), .req1_addr(a1), .req1_wdata(d1),
        .req1_busy(busy1), .req1_ack(ack1), .req1_rdata(rd1), .req1_err(err1),
        .rab_write(rw), .rab_read(rr), .rab_addr(raddr), .rab_wdata(rwd),
        .rab_ack(ack_in), .rab_rdata(rdata_in), .grant_id(gid)
    );

    rab_arbiter #(.RR_EN(1'b0), .TIMEOUT_CYC(TO), .TIMEOUT_RDATA(8'hFF)) fp (
        .sys_clk(clk), .io_resetb(rstb),
        .req0_write(w0), .req0_read(r0), .req0_addr(a0), .req0_wdata(d0),
        .req0_busy(f_busy0), .req0_ack(f_ack0), .req0_rdata(f_rd0), .req0_err(f_err0),
        .req1_write(w1), .req1_read(r1), .req1_addr(a1), .req1_wdata(d1),
        .req1_busy(f_busy1), .req1_ack(f_ack1), .req1_rdata(f_rd1), .req1_err(f_err1),
        .rab_write(f_rw), .rab_read(f_rr), .rab_addr(f_raddr), .rab_wdata(f_rwd),
        .rab_ack(ack_in), .rab_rdata(rdata_in), .grant_id(f_gid)
    );

    function automatic outs_t cur();
        outs_t o;
        o = '{b0: busy0, b1: busy1, k0: ack0, k1: ack1, e0: err0, e1: err1,
              rw: rw, rr: rr, addr: raddr, wd: rwd, gid: gid, rd0: rd0, rd1: rd1};
        return o;
    endfunction

    function automatic tin_t mkin(logic pw, logic pr, logic [8:0] a, logic [7:0] d,
                                  logic k, logic [7:0] ard);
        tin_t t;
        t = '{w0: pw, r0: pr, a0: a, d0: d, ack: k, ard: ard};
        return t;
    endfunction

    function automatic outs_t mkout(logic b, logic k, logic e, logic pw,
                                    logic [8:0] a, logic [7:0] d);
        outs_t o;
        o = '0;
        o.b0 = b; o.k0 = k; o.e0 = e; o.rw = pw; o.addr = a; o.wd = d;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic chk_o(input string nm, input outs_t exp);
        outs_t a;
        a = cur();
        n_chk++;
        if (a !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h (b0 b1 k0 k1 e0 e1 rw rr addr wd gid rd0 rd1)",
                     nm, a, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic pw0, input logic pr0, input logic pw1, input logic pr1,
                         input logic [8:0] a, input logic [7:0] d);
        w0 = pw0; r0 = pr0; a0 = a; d0 = d;
        w1 = pw1; r1 = pr1; a1 = a; d1 = d;
        step();
        w0 = 0; r0 = 0; w1 = 0; r1 = 0;
    endtask

    task automatic wait_strobe();
        for (int i = 0; i < 8; i++) begin
            if (rw || rr) break;
            step();
        end
        n_chk++;
        if (!(rw || rr)) begin
            n_err++;
            $display("FAIL rab_strobe_wait: got no strobe required one within 8 cycles");
        end
    endtask

    task automatic serve(input logic [7:0] d);
        ack_in = 1'b1;
        rdata_in = d;
        step();
        ack_in = 1'b0;
    endtask

    // Transaction-level reference: per-port queues of depth one, an active
    // transaction with its age in WAIT cycles, and the last-served port.
    function automatic void model_step();
        bit    full0, full1;
        mreq_t r;
        int    w;
        outs_t n;
        if (!rstb) begin
            mq0.delete(); mq1.delete();
            m_act = 0; m_rr = 1; m_exp = '0;
            return;
        end
        full0 = (mq0.size() != 0);
        full1 = (mq1.size() != 0);
        n = m_exp;
        n.k0 = 0; n.k1 = 0; n.e0 = 0; n.e1 = 0; n.rw = 0; n.rr = 0;
        if (m_act) begin
            m_age++;
            if (ack_in || m_age == TO) begin
                if (m_port == 0) begin
                    r = mq0.pop_front();
                    n.k0 = 1; n.e0 = !ack_in;
                    if (!r.wr) n.rd0 = ack_in ? rdata_in : 8'hFF;
                end else begin
                    r = mq1.pop_front();
                    n.k1 = 1; n.e1 = !ack_in;
                    if (!r.wr) n.rd1 = ack_in ? rdata_in : 8'hFF;
                end
                m_act = 0;
            end
        end else if (full0 || full1) begin
            if (full0 && full1) w = RR ? 1 - m_rr : 0;
            else w = full1 ? 1 : 0;
            r = (w == 1) ? mq1[0] : mq0[0];
            m_act = 1; m_port = w; m_age = 0; m_rr = w;
            n.gid = (w == 1); n.rw = r.wr; n.rr = !r.wr; n.addr = r.a; n.wd = r.d;
        end
        if (w0 || r0) begin
            if (full0) n.e0 = 1;
            else begin
                mq0.push_back('{wr: w0, a: a0, d: d0});
                if (w0 && r0) n.e0 = 1;
            end
        end
        if (w1 || r1) begin
            if (full1) n.e1 = 1;
            else begin
                mq1.push_back('{wr: w1, a: a1, d: d1});
                if (w1 && r1) n.e1 = 1;
            end
        end
        n.b0 = (mq0.size() != 0);
        n.b1 = (mq1.size() != 0);
        m_exp = n;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single write, overflow drops, write+read collision, drop while clearing.
        tbl[0]  = '{in: mkin(1, 0, 9'h012, 8'hA5, 0, 8'h00), ex: mkout(1, 0, 0, 0, 9'h000, 8'h00)};
        tbl[1]  = '{in: mkin(0, 0, 9'h000, 8'h00, 0, 8'h00), ex: mkout(1, 0, 0, 1, 9'h012, 8'hA5)};
        tbl[2]  = '{in: mkin(0, 0, 9'h000, 8'h00, 0, 8'h00), ex: mkout(1, 0, 0, 0, 9'h012, 8'hA5)};
        tbl[3]  = '{in: mkin(0, 0, 9'h000, 8'h00, 0, 8'h00), ex: mkout(1, 0, 0, 0, 9'h012, 8'hA5)};
        tbl[4]  = '{in: mkin(0, 0, 9'h000, 8'h00, 1, 8'h00), ex: mkout(0, 1, 0, 0, 9'h012, 8'hA5)};
        tbl[5]  = '{in: mkin(0, 0, 9'h000, 8'h00, 0, 8'h00), ex: mkout(0, 0, 0, 0, 9'h012, 8'hA5)};
        tbl[6]  = '{in: mkin(1, 0, 9'h055, 8'h11, 0, 8'h00), ex: mkout(1, 0, 0, 0, 9'h012, 8'hA5)};
        tbl[7]  = '{in: mkin(1, 0, 9'h066, 8'h22, 0, 8'h00), ex: mkout(1, 0, 1, 1, 9'h055, 8'h11)};
        tbl[8]  = '{in: mkin(0, 0, 9'h000, 8'h00, 0, 8'h00), ex: mkout(1, 0, 0, 0, 9'h055, 8'h11)};
        tbl[9]  = '{in: mkin(0, 0, 9'h000, 8'h00, 1, 8'h00), ex: mkout(0, 1, 0, 0, 9'h055, 8'h11)};
        tbl[10] = '{in: mkin(1, 1, 9'h077, 8'h33, 0, 8'h00), ex: mkout(1, 0, 1, 0, 9'h055, 8'h11)};
        tbl[11] = '{in: mkin(0, 0, 9'h000, 8'h00, 0, 8'h00), ex: mkout(1, 0, 0, 1, 9'h077, 8'h33)};
        tbl[12] = '{in: mkin(0, 0, 9'h000, 8'h00, 1, 8'h5A), ex: mkout(0, 1, 0, 0, 9'h077, 8'h33)};
        tbl[13] = '{in: mkin(0, 0, 9'h000, 8'h00, 0, 8'h00), ex: mkout(0, 0, 0, 0, 9'h077, 8'h33)};
        tbl[14] = '{in: mkin(1, 0, 9'h088, 8'h44, 0, 8'h00), ex: mkout(1, 0, 0, 0, 9'h077, 8'h33)};
        tbl[15] = '{in: mkin(0, 0, 9'h000, 8'h00, 0, 8'h00), ex: mkout(1, 0, 0, 1, 9'h088, 8'h44)};
        tbl[16] = '{in: mkin(1, 0, 9'h099, 8'h55, 1, 8'h00), ex: mkout(0, 1, 1, 0, 9'h088, 8'h44)};
        tbl[17] = '{in: mkin(0, 0, 9'h000, 8'h00, 0, 8'h00), ex: mkout(0, 0, 0, 0, 9'h088, 8'h44)};
        tbl[18] = '{in: mkin(0, 0, 9'h000, 8'h00, 0, 8'h00), ex: mkout(0, 0, 0, 0, 9'h088, 8'h44)};

        rstb = 1'b0;
        step();
        chk_o("reset_state", '0);
        rstb = 1'b1;

        for (int i = 0; i < 19; i++) begin
            w0 = tbl[i].in.w0; r0 = tbl[i].in.r0; a0 = tbl[i].in.a0; d0 = tbl[i].in.d0;
            ack_in = tbl[i].in.ack; rdata_in = tbl[i].in.ard;
            step();
            chk_o($sformatf("vec%0d", i), tbl[i].ex);
        end
        w0 = 0; r0 = 0; ack_in = 0; rdata_in = 0;

        // Read return on port 1, then held across port-0 traffic.
        issue(0, 0, 0, 1, 9'h1F0, 8'h00);
        chk("rd1_busy", 32'(busy1), 32'd1);
        wait_strobe();
        chk("rd1_strobe", {rw, rr, gid, raddr}, {1'b0, 1'b1, 1'b1, 9'h1F0});
        serve(8'h3C);
        chk("rd1_ack", {ack1, err1, busy1, rd1}, {1'b1, 1'b0, 1'b0, 8'h3C});
        step();
        issue(1, 0, 0, 0, 9'h0AA, 8'h5E);
        wait_strobe();
        serve(8'h77);
        chk("wr0_ack_hold", {ack0, rd0, rd1}, {1'b1, 8'h00, 8'h3C});
        step();
        issue(0, 1, 0, 0, 9'h0AB, 8'h00);
        wait_strobe();
        serve(8'h77);
        chk("rd0_ack_hold", {ack0, rd0, rd1}, {1'b1, 8'h77, 8'h3C});
        step();

        // Contention: simultaneous reads on both ports, four rounds.
        rstb = 1'b0; step(); rstb = 1'b1;
        for (int k = 0; k < 4; k++) begin
            issue(0, 1, 0, 1, 9'(9'h100 + k), 8'h00);
            for (int j = 0; j < 2; j++) begin
                wait_strobe();
                chk($sformatf("rr_grant_r%0d_%0d", k, j), 32'(gid), 32'(j));
                chk($sformatf("fp_grant_r%0d_%0d", k, j), {f_rr, f_gid}, {1'b1, 1'(j)});
                serve(8'h00);
            end
            step();
        end
        // After port 0 was served last, round-robin favours port 1; fixed priority does not.
        issue(1, 0, 0, 0, 9'h010, 8'h01);
        wait_strobe();
        serve(8'h00);
        step();
        issue(0, 1, 0, 1, 9'h020, 8'h00);
        wait_strobe();
        chk("rr_after_p0", 32'(gid), 32'd1);
        chk("fp_after_p0", 32'(f_gid), 32'd0);
        serve(8'h00);
        wait_strobe();
        chk("rr_second", 32'(gid), 32'd0);
        chk("fp_second", 32'(f_gid), 32'd1);
        serve(8'h00);
        step();

        // Timeout on a read with no rab_ack, then a late ack that must be ignored.
        rstb = 1'b0; step(); rstb = 1'b1;
        issue(0, 1, 0, 0, 9'h033, 8'h00);
        wait_strobe();
        repeat (3) step();
        chk("tmo_pre", {ack0, err0, busy0}, {1'b0, 1'b0, 1'b1});
        step();
        chk("tmo_fire", {ack0, err0, busy0, rd0}, {1'b1, 1'b1, 1'b0, 8'hFF});
        serve(8'h99);
        chk("late_ack", {ack0, err0, rw, rr, rd0}, {1'b0, 1'b0, 1'b0, 1'b0, 8'hFF});
        step();
        chk("late_ack_idle", {busy0, ack0, rr}, 3'b000);
        // Ack in the same cycle the limit is reached: normal completion.
        issue(0, 1, 0, 0, 9'h034, 8'h00);
        wait_strobe();
        repeat (3) step();
        serve(8'h6B);
        chk("ack_at_limit", {ack0, err0, rd0}, {1'b1, 1'b0, 8'h6B});
        step();

        // Reset during WAIT aborts silently and restores port-0 first priority.
        issue(1, 0, 0, 0, 9'h1AA, 8'hC3);
        wait_strobe();
        step();
        rstb = 1'b0;
        step();
        rstb = 1'b1;
        chk_o("rst_mid_wait", '0);
        serve(8'h12);
        chk_o("ack_in_idle", '0);
        issue(0, 1, 0, 1, 9'h0C0, 8'h00);
        wait_strobe();
        chk("post_rst_grant", {rr, gid}, {1'b1, 1'b0});
        serve(8'h00);
        wait_strobe();
        chk("post_rst_grant2", 32'(gid), 32'd1);
        serve(8'h00);
        step();

        // Randomized traffic against the reference model.
        rstb = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            model_step();
            #1;
            chk_o($sformatf("rand%0d", c), m_exp);
            rstb = ($urandom_range(0, 249) != 0);
            w0 = ($urandom_range(0, 5) == 0);
            r0 = ($urandom_range(0, 5) == 0);
            w1 = ($urandom_range(0, 5) == 0);
            r1 = ($urandom_range(0, 5) == 0);
            a0 = 9'($urandom); d0 = 8'($urandom);
            a1 = 9'($urandom); d1 = 8'($urandom);
            ack_in = ($urandom_range(0, 3) == 0);
            rdata_in = 8'($urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
